// File: rtl/ds_pkg.sv
// Shared definitions for the downsample writeback block: FSM state
// encoding, stored pixel width and the saturation ceiling.
package ds_pkg;

    localparam int PIX_W = 8;

    localparam logic [PIX_W-1:0] SAT_MAX = 8'd255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAST = 2'd2,
        DONE = 2'd3
    } ds_state_e;

endpackage

// File: rtl/ds_out_ram.sv
// Output frame buffer: one write port and one registered read port.
// A read and a write to the same address on one edge return the old value.
// Reads beyond DEPTH return zero.
module ds_out_ram
    import ds_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [15:0]      waddr,
    input  logic [PIX_W-1:0] wdata,
    input  logic [15:0]      raddr,
    output logic [PIX_W-1:0] rdata
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PIX_W-1:0] mem [0:DEPTH-1];
    logic [PIX_W-1:0] rdata_d;
    logic [PIX_W-1:0] rdata_q;

    // Select the addressed word, or zero when the address is past the frame.
    always_comb begin
        rdata_d = {PIX_W{1'b0}};
        if (raddr < 16'(DEPTH)) begin
            rdata_d = mem[raddr[AW-1:0]];
        end else begin
            rdata_d = {PIX_W{1'b0}};
        end
    end

    // Register the read data; reset clears it so readout starts at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= {PIX_W{1'b0}};
        end else begin
            rdata_q <= rdata_d;
        end
    end

    // Buffer write; storage itself is not reset and holds between frames.
    always_ff @(posedge clk) begin
        if (we && (waddr < 16'(DEPTH))) begin
            mem[waddr[AW-1:0]] <= wdata;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ds_writeback.sv
// Downsample writeback: accepts one kernel result per handshake, converts it
// to an 8-bit pixel and writes it raster-order into the output buffer.
// Build option: define DS_WRITEBACK_SAT_EN to clamp results above 255 to 255;
// by default only the low 8 bits are stored.
module ds_writeback
    import ds_pkg::*;
#(
    parameter int OUT_W = 8,
    parameter int OUT_H = 8,
    parameter int IN_W  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [IN_W-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [15:0]     rd_addr,
    output logic [7:0]      rd_data,
    output logic            busy,
    output logic            done,
    output logic [7:0]      col,
    output logic [7:0]      row
);

    ds_state_e        state_d, state_q;
    logic [7:0]       col_d, col_q;
    logic [7:0]       row_d, row_q;
    logic             in_ready_d, in_ready_q;
    logic             busy_d, busy_q;
    logic             done_d, done_q;
    logic             wr_en_d, wr_en_q;
    logic [15:0]      wr_addr_d, wr_addr_q;
    logic [PIX_W-1:0] wr_data_d, wr_data_q;

    logic             accept_s;
    logic [15:0]      pos_addr_s;
    logic [PIX_W-1:0] pix_s;

`ifdef DS_WRITEBACK_SAT_EN
    // Clamp oversized kernel results to the brightest pixel value.
    always_comb begin
        pix_s = in_data[PIX_W-1:0];
        if (in_data > IN_W'(SAT_MAX)) begin
            pix_s = SAT_MAX;
        end else begin
            pix_s = in_data[PIX_W-1:0];
        end
    end
`else
    // Upper result bits are deliberately discarded in the wrap-around build.
    logic unused_in_hi_s;
    assign unused_in_hi_s = ^in_data;

    // Keep only the low byte of the kernel result.
    always_comb begin
        pix_s = in_data[PIX_W-1:0];
    end
`endif

    assign accept_s   = in_valid && in_ready_q;
    assign pos_addr_s = 16'(row_q) * 16'(OUT_W) + 16'(col_q);

    // Next-state logic: frame sequencing, raster position and write staging.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        in_ready_d = in_ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    col_d      = 8'd0;
                    row_d      = 8'd0;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b1;
                end else begin
                    state_d    = IDLE;
                end
            end
            RUN: begin
                if (accept_s) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = pos_addr_s;
                    wr_data_d = pix_s;
                    if (col_q == 8'(OUT_W - 1)) begin
                        col_d = 8'd0;
                        row_d = row_q + 8'd1;
                        if (row_q == 8'(OUT_H - 1)) begin
                            state_d    = LAST;
                            in_ready_d = 1'b0;
                        end else begin
                            state_d    = RUN;
                        end
                    end else begin
                        col_d = col_q + 8'd1;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            LAST: begin
                // The final staged pixel lands in the buffer on this edge.
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d    = IDLE;
                in_ready_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State and output registers; reset also drops any staged write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            col_q      <= 8'd0;
            row_q      <= 8'd0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 16'd0;
            wr_data_q  <= {PIX_W{1'b0}};
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    ds_out_ram #(
        .DEPTH (OUT_W * OUT_H)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en_q),
        .waddr (wr_addr_q),
        .wdata (wr_data_q),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign col      = col_q;
    assign row      = row_q;

endmodule

// File: tb/tb_ds_writeback.sv
// Directed bench for ds_writeback: a 2x2 instance for frame, saturation,
// handshake, collision and reset checks, and a 3x2 instance for column wrap.
module tb_ds_writeback;

    logic        clk;
    logic        rst;

    logic        start, in_valid, in_ready, busy, done;
    logic [15:0] in_data, rd_addr;
    logic [7:0]  rd_data, col, row;

    logic        start3, in_valid3, in_ready3, busy3, done3;
    logic [15:0] in_data3, rd_addr3;
    logic [7:0]  rd_data3, col3, row3;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef DS_WRITEBACK_SAT_EN
    localparam logic [7:0] EXP300 = 8'd255;
`else
    localparam logic [7:0] EXP300 = 8'd44;
`endif

    ds_writeback #(.OUT_W(2), .OUT_H(2), .IN_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .rd_addr(rd_addr),
        .rd_data(rd_data), .busy(busy), .done(done), .col(col), .row(row)
    );

    ds_writeback #(.OUT_W(3), .OUT_H(2), .IN_W(16)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .in_data(in_data3),
        .in_valid(in_valid3), .in_ready(in_ready3), .rd_addr(rd_addr3),
        .rd_data(rd_data3), .busy(busy3), .done(done3), .col(col3), .row(row3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] addr, input logic [7:0] exp);
        rd_addr = addr;
        tick();
        chk(tag, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; in_valid = 1'b0; in_data = 16'd0; rd_addr = 16'd0;
        start3 = 1'b0; in_valid3 = 1'b0; in_data3 = 16'd0; rd_addr3 = 16'd0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_col", 32'(col), 32'd0);
        chk("rst_row", 32'(row), 32'd0);
        chk("rst_rdata", 32'(rd_data), 32'd0);
        rst = 1'b0;
        tick();

        // Frame 1: 10,20,30,40 with in_valid held high.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("f1_ready", 32'(in_ready), 32'd1);
        chk("f1_busy", 32'(busy), 32'd1);
        in_valid = 1'b1; in_data = 16'd10; tick();
        in_data = 16'd20; tick();
        chk("f1_wrap_col", 32'(col), 32'd0);
        chk("f1_wrap_row", 32'(row), 32'd1);
        in_data = 16'd30; tick();
        in_data = 16'd40; tick();
        in_valid = 1'b0;
        chk("f1_last_busy", 32'(busy), 32'd1);
        chk("f1_last_ready", 32'(in_ready), 32'd0);
        chk("f1_last_done", 32'(done), 32'd0);
        tick();
        chk("f1_done_pulse", 32'(done), 32'd1);
        chk("f1_done_busy", 32'(busy), 32'd0);
        tick();
        chk("f1_done_clear", 32'(done), 32'd0);
        rd_chk("f1_buf0", 16'd0, 8'd10);
        rd_chk("f1_buf1", 16'd1, 8'd20);
        rd_chk("f1_buf2", 16'd2, 8'd30);
        rd_chk("f1_buf3", 16'd3, 8'd40);

        // Frame 2: 300 conversion, same-address read, stray start, toggled valid.
        rd_addr = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 16'd300; tick();
        chk("f2_col_a", 32'(col), 32'd1);
        in_valid = 1'b0; start = 1'b1; tick();
        start = 1'b0;
        chk("f2_rw_old", 32'(rd_data), 32'd10);
        chk("f2_hold_col", 32'(col), 32'd1);
        chk("f2_hold_row", 32'(row), 32'd0);
        chk("f2_stray_busy", 32'(busy), 32'd1);
        tick();
        chk("f2_conv300", 32'(rd_data), 32'(EXP300));
        in_valid = 1'b1; in_data = 16'd5; tick();
        in_valid = 1'b0; tick();
        chk("f2_gap_col", 32'(col), 32'd0);
        chk("f2_gap_row", 32'(row), 32'd1);
        in_valid = 1'b1; in_data = 16'd6; tick();
        in_valid = 1'b0; tick();
        chk("f2_gap2_col", 32'(col), 32'd1);
        in_valid = 1'b1; in_data = 16'd7; tick();
        in_valid = 1'b0;
        tick();
        chk("f2_done", 32'(done), 32'd1);
        tick();
        rd_chk("f2_buf1", 16'd1, 8'd5);
        rd_chk("f2_buf2", 16'd2, 8'd6);
        rd_chk("f2_buf3", 16'd3, 8'd7);
        rd_chk("f2_oob", 16'd4, 8'd0);
        rd_chk("f2_buf0", 16'd0, EXP300);

        // Frame 3: reset after two samples; later in_valid must be ignored.
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 16'd11; tick();
        in_data = 16'd12; tick();
        chk("f3_pre_col", 32'(col), 32'd0);
        chk("f3_pre_row", 32'(row), 32'd1);
        in_data = 16'd99;
        rst = 1'b1;
        #1;
        chk("f3_rst_busy", 32'(busy), 32'd0);
        chk("f3_rst_col", 32'(col), 32'd0);
        chk("f3_rst_row", 32'(row), 32'd0);
        chk("f3_rst_ready", 32'(in_ready), 32'd0);
        chk("f3_rst_rdata", 32'(rd_data), 32'd0);
        tick();
        rst = 1'b0;
        tick(); tick(); tick();
        chk("f3_ign_col", 32'(col), 32'd0);
        chk("f3_ign_row", 32'(row), 32'd0);
        chk("f3_ign_busy", 32'(busy), 32'd0);
        in_valid = 1'b0;

        // 3-wide instance: column wraps 2 -> 0 and row goes 0 -> 1.
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        in_valid3 = 1'b1; in_data3 = 16'd1; tick();
        in_data3 = 16'd2; tick();
        chk("w3_col2", 32'(col3), 32'd2);
        chk("w3_row0", 32'(row3), 32'd0);
        in_data3 = 16'd3; tick();
        in_valid3 = 1'b0;
        chk("w3_col_wrap", 32'(col3), 32'd0);
        chk("w3_row_inc", 32'(row3), 32'd1);
        chk("w3_ready", 32'(in_ready3), 32'd1);
        chk("w3_done", 32'(done3), 32'd0);
        rd_addr3 = 16'd1;
        tick();
        chk("w3_buf1", 32'(rd_data3), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ds_writeback.md
DS_WRITEBACK -- requirements
Module: ds_writeback

Interface
- REQ-001: Parameter OUT_W, default 8, output image width in pixels (1..255).
- REQ-002: Parameter OUT_H, default 8, output image height in pixels (1..255).
- REQ-003: Parameter IN_W, default 16, width of incoming kernel result.
- REQ-004: Port clk, input, 1, sole clock; all state updates on rising edge.
- REQ-005: Port rst, input, 1, reset; asynchronous and active-high.
- REQ-006: Port start, input, 1, one-cycle pulse that begins a frame.
- REQ-007: Port in_data, input, IN_W, downsampled kernel result from the kernel CU.
- REQ-008: Port in_valid, input, 1, in_data is valid this cycle.
- REQ-009: Port in_ready, output, 1, block accepts in_data this cycle.
- REQ-010: Port rd_addr, input, 16, readout address into the output buffer.
- REQ-011: Port rd_data, output, 8, pixel at rd_addr, registered.
- REQ-012: Port busy, output, 1, frame in progress.
- REQ-013: Port done, output, 1, one-cycle pulse after the last pixel is written.
- REQ-014: Port col, output, 8, current column. Port row, output, 8, current row.

Function
- REQ-015: FSM states are IDLE, RUN, LAST, DONE; reset state is IDLE.
- REQ-016: IDLE -> RUN on start; col and row clear to 0 on that edge.
- REQ-017: in_ready SHALL be 1 only in RUN; a sample is accepted when in_valid and in_ready are both 1 on a rising edge.
- REQ-018: Each accepted sample is converted to 8 bits (REQ-027/028), registered, and written to buffer address row*OUT_W+col on the following edge (write latency 1 cycle).
- REQ-019: After each acceptance col increments; when col==OUT_W-1 it wraps to 0 and row increments.
- REQ-020: Acceptance at col==OUT_W-1 and row==OUT_H-1 moves RUN -> LAST; LAST performs the final write and moves to DONE.
- REQ-021: DONE asserts done for exactly one cycle, then returns to IDLE; buffer contents are held.
- REQ-022: start outside IDLE is ignored; an in_valid with in_ready low is neither accepted nor lost-tracked (upstream holds it).
- REQ-023: busy is 1 in RUN and LAST, 0 otherwise.
- REQ-024: rd_data returns buffer[rd_addr] one cycle after rd_addr, in any state; rd_addr >= OUT_W*OUT_H returns 0.
- REQ-025: A read and a write to the same address in one cycle returns the old value.

Reset
- REQ-026: rst asynchronously forces IDLE, in_ready=0, busy=0, done=0, col=0, row=0, rd_data=0, and cancels any pending write; buffer contents are undefined after reset. Reset mid-frame requires a new start.

Configuration
- REQ-027: With macro DS_WRITEBACK_SAT_EN defined, in_data > 255 is stored as 255; otherwise in_data[7:0] is stored.
- REQ-028: Without DS_WRITEBACK_SAT_EN, only the low 8 bits are stored (wrap-around, e.g. 300 -> 44).

Structure
- REQ-029: Shared package ds_pkg holds the FSM state encoding, PIX_W=8 and the saturation constant 255.
- REQ-030: The buffer is a separate sub-module ds_out_ram (1 write port, 1 registered read port, depth OUT_W*OUT_H).

Verification
- REQ-031: OUT_W=2, OUT_H=2, start, then feed 10,20,30,40 with in_valid held high -> buffer[0..3]=10,20,30,40; done pulses once, 1 cycle after the fourth write.
- REQ-032: in_data=300 with DS_WRITEBACK_SAT_EN defined -> stored 255; without the macro -> stored 44.
- REQ-033: in_valid toggles 1,0,1,0 -> col advances only on cycles where in_valid=1; no duplicate or skipped writes.
- REQ-034: OUT_W=3, feed 3 samples -> col wraps 2->0 and row goes 0->1.
- REQ-035: rst asserted after 2 of 4 samples -> busy=0, col=row=0 immediately; without a new start, in_valid is ignored.
- REQ-036: start while busy -> ignored; frame completes with col and row unchanged by the stray start.
